// File: rtl/i2c_nios_lcd_hd44780_timed_pkg.sv
// Shared types and constants for the timed HD44780 LCD Avalon port.
package lcd_hd44780_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_RECOVER,
    ST_DONE
  } lcd_state_e;

  localparam int unsigned ADDR_RS_BIT = 1;
  localparam int unsigned ADDR_RW_BIT = 0;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_nios_lcd_hd44780_timed_if.sv
// Avalon-MM slave port bundle between the Nios interconnect and the LCD controller.
interface i2c_nios_lcd_hd44780_timed_if;
  logic [1:0] address;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;

  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/i2c_nios_lcd_hd44780_timed_timer.sv
// Phase timer: loads N-1 on phase entry, counts down, flags zero; never wraps.
module lcd_phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_nios_lcd_hd44780_timed.sv
// Avalon-MM slave generating HD44780 bus timing in hardware, 8-bit or 4-bit bus,
// stalling the host with waitrequest for the whole LCD cycle.
module i2c_nios_lcd_hd44780_timed
  import lcd_hd44780_pkg::*;
#(
  parameter int unsigned BUS_MODE    = 8,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_HI_CYC   = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 25
) (
  input  logic                          clk,
  input  logic                          reset_n,
  i2c_nios_lcd_hd44780_timed_if.slave   avs,
  output logic                          LCD_E,
  output logic                          LCD_RS,
  output logic                          LCD_RW,
  inout  wire  [7:0]                    LCD_data
);

  localparam int unsigned CW =
    $clog2(max(max(SETUP_CYC, EN_HI_CYC), max(HOLD_CYC, RECOVER_CYC))) + 1;
  localparam bit NIBBLE_MODE = (BUS_MODE == 4);

  lcd_state_e state_q, state_d;
  logic       e_q, e_d;
  logic       rs_q, rs_d;
  logic       rw_q, rw_d;
  logic       drive_q, drive_d;
  logic       wr_op_q, wr_op_d;
  logic       nib_q, nib_d;
  logic [7:0] bus_q, bus_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;

  logic          req;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;

  lcd_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign req = avs.read | avs.write;

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    drive_d  = drive_q;
    wr_op_d  = wr_op_q;
    nib_d    = nib_q;
    bus_d    = bus_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_SETUP;
          rs_d     = avs.address[ADDR_RS_BIT];
          rw_d     = avs.address[ADDR_RW_BIT];
          wr_op_d  = avs.write;
          wdata_d  = avs.writedata;
          nib_d    = 1'b0;
          // never fight the LCD: only drive when the LCD itself is in write direction
          drive_d  = avs.write & ~avs.address[ADDR_RW_BIT];
          bus_d    = NIBBLE_MODE ? {avs.writedata[7:4], 4'h0} : avs.writedata;
          tmr_load = 1'b1;
          tmr_val  = CW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_EN_HI;
          e_d      = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CW'(EN_HI_CYC - 1);
        end
      end
      ST_EN_HI: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          e_d      = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = CW'(HOLD_CYC - 1);
          if (!wr_op_q) begin
            if (!NIBBLE_MODE) begin
              rdata_d = LCD_data;
            end else if (!nib_q) begin
              rdata_d[7:4] = LCD_data[7:4];
            end else begin
              rdata_d[3:0] = LCD_data[7:4];
            end
          end
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (NIBBLE_MODE && !nib_q) begin
            state_d = ST_SETUP;
            nib_d   = 1'b1;
            bus_d   = {wdata_q[3:0], 4'h0};
            tmr_val = CW'(SETUP_CYC - 1);
          end else begin
            state_d = ST_RECOVER;
            drive_d = 1'b0;
            rw_d    = 1'b1;
            tmr_val = CW'(RECOVER_CYC - 1);
          end
        end
      end
      ST_RECOVER: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      drive_q <= 1'b0;
      wr_op_q <= 1'b0;
      nib_q   <= 1'b0;
      bus_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      drive_q <= drive_d;
      wr_op_q <= wr_op_d;
      nib_q   <= nib_d;
      bus_q   <= bus_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs.waitrequest = req & (state_q != ST_DONE);
  assign avs.readdata    = rdata_q;
  assign LCD_E           = e_q;
  assign LCD_RS          = rs_q;
  assign LCD_RW          = rw_q;
  assign LCD_data        = drive_q ? bus_q : 'z;

endmodule
